irq_pending_ctrl: RTL and testbench
===================================

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, default 8, number of request lines; 8 is the only supported value.
REQ-002 SHALL have parameter IDX_W, default 3, grant index width, equal to clog2(NUM_REQ).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_i  in  8  request lines; bit i is request source i.
REQ-007 mask_i  in  8  enable mask; 1 = source enabled.
REQ-008 clr_i  in  8  software clear of pending bits, one cycle per pulse.
REQ-009 enc_in_o  out  8  masked pending vector, driven to the priority encoder input.
REQ-010 enc_out_i  in  3  winning index from the encoder; lowest set bit wins.
REQ-011 enc_valid_i  in  1  encoder "any bit set" flag.
REQ-012 gnt_valid_o  out  1  grant offered.
REQ-013 gnt_ready_i  in  1  grant accepted by the consumer.
REQ-014 gnt_idx_o  out  3  granted source index.
REQ-015 pending_o  out  8  raw (unmasked) pending register.
REQ-016 ovf_o  out  1  sticky overflow: an event arrived on a bit that was already pending.
REQ-017 ovf_clr_i  in  1  clears ovf_o.

Function
REQ-018 enc_in_o SHALL equal pending & mask_i, combinationally, with no register stage.
REQ-019 A request event on bit i SHALL set pending[i] on the next rising edge; the event definition is set by REQ-031 and REQ-032.
REQ-020 pending[i] SHALL clear on a grant handshake with gnt_idx_o==i, or when clr_i[i]=1.
REQ-021 If a set and a clear hit the same bit in the same cycle, set SHALL win; the bit stays 1 and ovf_o is not raised.
REQ-022 FSM states SHALL be IDLE and OFFER; the reset state is IDLE.
REQ-023 IDLE: when enc_valid_i=1, register enc_out_i into gnt_idx and go to OFFER; otherwise stay in IDLE.
REQ-024 OFFER: gnt_valid_o=1 and gnt_idx_o held stable until gnt_ready_i=1; the handshake is gnt_valid_o & gnt_ready_i.
REQ-025 On handshake: clear pending[gnt_idx] and return to IDLE; throughput is at most one grant per 2 cycles.
REQ-026 Once offered, a grant SHALL NOT be retracted or changed, even if its bit is masked or cleared by clr_i during OFFER.
REQ-027 gnt_valid_o SHALL be 0 in IDLE.
REQ-028 gnt_valid_o SHALL NOT depend combinationally on gnt_ready_i.
REQ-029 ovf_o SHALL set when an event hits a bit with pending=1 that is not being cleared in that cycle; ovf_clr_i clears ovf_o; if both occur in the same cycle, set wins.

Reset
REQ-030 On rst_n=0: pending=0, ovf_o=0, FSM=IDLE, gnt_valid_o=0, gnt_idx_o=0, synchronizer flops=0; no grant is issued until after reset deasserts; an in-flight grant is dropped.

Configuration
REQ-031 With IRQ_EDGE_DETECT_EN defined, req_i SHALL pass through a 2-flop synchronizer plus a previous-value flop; an event is a rising edge of the synchronized signal. Latency from req_i rise to pending set is 3 cycles.
REQ-032 Without IRQ_EDGE_DETECT_EN, an event is req_i[i]=1 in any cycle (level, sticky into pending), with 1-cycle latency, and ovf_o is tied to 0.

Structure
REQ-033 Package irq_pending_pkg SHALL hold NUM_REQ, IDX_W and the FSM state enum (IDLE, OFFER).
REQ-034 Sub-module irq_edge_sync (synchronizer plus edge detect, 8-bit vector) SHALL be instantiated only under IRQ_EDGE_DETECT_EN.
REQ-035 The priority encoder SHALL remain external; this block SHALL NOT duplicate it.

Verification
REQ-036 The bench SHALL pair the block with a behavioural lowest-bit encoder and cover:
- Level mode, req_i=8'h00 -> 8'h28 for 1 cycle, mask=8'hFF, ready=1 -> grants idx 3 then idx 5, each 2 cycles apart; pending ends at 8'h00.
- mask_i=8'hF7, pending=8'h08 -> enc_in_o=8'h00 and no grant; changing mask to 8'hFF -> grant idx 3.
- In OFFER with idx 2, gnt_ready_i=0 for 5 cycles while clr_i=8'h04 -> gnt_valid_o stays 1 and gnt_idx_o stays 2; ready=1 -> exactly one handshake.
- Edge mode: req_i bit 1 held high for 10 cycles -> exactly one pending set, 3 cycles after the rise; a second rising edge before the grant -> ovf_o=1; ovf_clr_i -> ovf_o=0.
- Set/clear collision: new event on idx 4 in the same cycle as its handshake -> pending[4] stays 1, ovf_o=0, and a second grant for idx 4 follows.
- rst_n asserted during OFFER -> gnt_valid_o=0 and pending=0 immediately (asynchronous); the first grant after release requires a new request.

Source files
------------

// File: rtl/irq_pending_pkg.sv
// Shared constants and FSM state type for the interrupt pending/grant controller.
// Optional build macro IRQ_EDGE_DETECT_EN is consumed by irq_pending_ctrl.
package irq_pending_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } gnt_state_e;

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer plus previous-value flop per request line; emits a
// one-cycle event on each rising edge of the synchronized signal.
module irq_edge_sync
   import irq_pending_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] req_i,
   output logic [W-1:0] evt_o
);

   logic [W-1:0] sync1_reg;
   logic [W-1:0] sync2_reg;
   logic [W-1:0] prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         prev_reg  <= '0;
      end else begin
         sync1_reg <= req_i;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_edge
         assign evt_o[gi] = sync2_reg[gi] & ~prev_reg[gi];
      end
   endgenerate

endmodule

// File: rtl/irq_pending_ctrl.sv
// Pending-interrupt register with mask, external lowest-bit encoder hookup and
// a two-state grant handshake. Define IRQ_EDGE_DETECT_EN for edge-triggered requests.
module irq_pending_ctrl
   import irq_pending_pkg::*;
#(
   parameter int NUM_REQ = irq_pending_pkg::NUM_REQ,
   parameter int IDX_W   = irq_pending_pkg::IDX_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] mask_i,
   input  logic [NUM_REQ-1:0] clr_i,
   output logic [NUM_REQ-1:0] enc_in_o,
   input  logic [IDX_W-1:0]   enc_out_i,
   input  logic               enc_valid_i,
   output logic               gnt_valid_o,
   input  logic               gnt_ready_i,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic [NUM_REQ-1:0] pending_o,
   output logic               ovf_o,
   input  logic               ovf_clr_i
);

   logic [NUM_REQ-1:0] evt;
   logic [NUM_REQ-1:0] clr_vec;
   logic [NUM_REQ-1:0] ovf_hit;
   logic [NUM_REQ-1:0] pending_reg;
   logic [NUM_REQ-1:0] pending_next;
   gnt_state_e         state_reg;
   gnt_state_e         state_next;
   logic [IDX_W-1:0]   gnt_idx_reg;
   logic [IDX_W-1:0]   gnt_idx_next;
   logic               hs;

`ifdef IRQ_EDGE_DETECT_EN
   irq_edge_sync #(.W(NUM_REQ)) u_edge_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (req_i),
      .evt_o (evt)
   );
`else
   assign evt = req_i;
`endif

   assign hs = (state_reg == OFFER) && gnt_ready_i;

   // Set wins over both clear sources, so a colliding event keeps the bit
   // pending and is not counted as an overflow.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_bit
         assign clr_vec[gi]      = clr_i[gi] | (hs && (gnt_idx_reg == IDX_W'(gi)));
         assign pending_next[gi] = evt[gi] | (pending_reg[gi] & ~clr_vec[gi]);
         assign ovf_hit[gi]      = evt[gi] & pending_reg[gi] & ~clr_vec[gi];
      end
   endgenerate

   always_comb begin
      state_next   = state_reg;
      gnt_idx_next = gnt_idx_reg;
      case (state_reg)
         IDLE: begin
            if (enc_valid_i) begin
               gnt_idx_next = enc_out_i;
               state_next   = OFFER;
            end
         end
         OFFER: begin
            if (gnt_ready_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg <= '0;
         state_reg   <= IDLE;
         gnt_idx_reg <= '0;
      end else begin
         pending_reg <= pending_next;
         state_reg   <= state_next;
         gnt_idx_reg <= gnt_idx_next;
      end
   end

`ifdef IRQ_EDGE_DETECT_EN
   logic ovf_reg;
   logic ovf_next;

   assign ovf_next = (|ovf_hit) | (ovf_reg & ~ovf_clr_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_reg <= 1'b0;
      end else begin
         ovf_reg <= ovf_next;
      end
   end

   assign ovf_o = ovf_reg;
`else
   // A held level request re-hits its own pending bit every cycle, so overflow
   // has no meaning in level mode.
   logic unused_ovf;
   assign unused_ovf = ovf_clr_i | (|ovf_hit);
   assign ovf_o      = 1'b0;
`endif

   assign enc_in_o    = pending_reg & mask_i;
   assign pending_o   = pending_reg;
   assign gnt_valid_o = (state_reg == OFFER);
   assign gnt_idx_o   = gnt_idx_reg;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench: stimulus queues expected grant indices, a monitor pops
// and compares them on every observed handshake.
module tb_irq_pending_ctrl;

`ifdef IRQ_EDGE_DETECT_EN
   localparam int EVT_LAT = 3;
   localparam bit EDGE    = 1'b1;
`else
   localparam int EVT_LAT = 1;
   localparam bit EDGE    = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req_i, mask_i, clr_i, enc_in;
   logic [2:0] enc_out, gnt_idx_o;
   logic       enc_valid, gnt_valid_o, gnt_ready_i, ovf_o, ovf_clr_i;
   logic [7:0] pending_o;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int hs_cnt = 0;
   int hs_last_cyc = 0;
   int hs_prev_cyc = 0;
   int exp_q[$];
   logic       prev_wait = 1'b0;
   logic [2:0] prev_idx  = 3'd0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural lowest-set-bit encoder
   always_comb begin
      enc_valid = |enc_in;
      enc_out   = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (enc_in[i]) enc_out = 3'(i);
      end
   end

   irq_pending_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .mask_i      (mask_i),
      .clr_i       (clr_i),
      .enc_in_o    (enc_in),
      .enc_out_i   (enc_out),
      .enc_valid_i (enc_valid),
      .gnt_valid_o (gnt_valid_o),
      .gnt_ready_i (gnt_ready_i),
      .gnt_idx_o   (gnt_idx_o),
      .pending_o   (pending_o),
      .ovf_o       (ovf_o),
      .ovf_clr_i   (ovf_clr_i)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end else begin
         $display("ok   %s value=0x%0h", name, act);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_empty(input string name, input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_valid(input string name, input int budget);
      int k = 0;
      while (!gnt_valid_o && k < budget) begin
         tick();
         k++;
      end
      check(name, 32'(gnt_valid_o), 32'd1);
   endtask

   // monitor: grant stability while stalled, and scoreboard compare on handshake
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (prev_wait) begin
               check("hold_valid", 32'(gnt_valid_o), 32'd1);
               check("hold_idx", 32'(gnt_idx_o), 32'(prev_idx));
            end
            if (gnt_valid_o && gnt_ready_i) begin
               hs_cnt++;
               hs_prev_cyc = hs_last_cyc;
               hs_last_cyc = cyc;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_grant actual_idx=%0d required=no grant", gnt_idx_o);
               end else begin
                  check("grant_idx", 32'(gnt_idx_o), 32'(exp_q.pop_front()));
               end
            end
            prev_wait = gnt_valid_o && !gnt_ready_i;
            prev_idx  = gnt_idx_o;
         end else begin
            prev_wait = 1'b0;
         end
      end
   end

   initial begin
      int h0;
      rst_n = 1'b0; req_i = '0; mask_i = '0; clr_i = '0;
      gnt_ready_i = 1'b0; ovf_clr_i = 1'b0;
      tick(3);
      @(negedge clk);
      check("rst_pending", 32'(pending_o), 32'h0);
      check("rst_valid", 32'(gnt_valid_o), 32'd0);
      check("rst_idx", 32'(gnt_idx_o), 32'd0);
      check("rst_ovf", 32'(ovf_o), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // two simultaneous requests drain lowest-first, one grant every 2 cycles
      mask_i = 8'hFF; gnt_ready_i = 1'b1;
      exp_q.push_back(3); exp_q.push_back(5);
      req_i = 8'h28;
      tick();
      req_i = 8'h00;
      tick(EVT_LAT - 1);
      @(negedge clk);
      check("t1_pending_set", 32'(pending_o), 32'h28);
      wait_empty("t1_drain", 20);
      check("t1_spacing", 32'(hs_last_cyc - hs_prev_cyc), 32'd2);
      check("t1_pending_end", 32'(pending_o), 32'h00);

      // masked pending bit is invisible to the encoder until unmasked
      mask_i = 8'hF7;
      req_i = 8'h08;
      tick();
      req_i = 8'h00;
      tick(EVT_LAT + 3);
      check("t2_pending", 32'(pending_o), 32'h08);
      check("t2_enc_in", 32'(enc_in), 32'h00);
      check("t2_no_grant", 32'(gnt_valid_o), 32'd0);
      req_i = 8'h08;
      tick();
      req_i = 8'h00;
      tick(EVT_LAT + 1);
      check("t2_ovf", 32'(ovf_o), 32'(EDGE));
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      check("t2_ovf_clr", 32'(ovf_o), 32'd0);
      exp_q.push_back(3);
      mask_i = 8'hFF;
      #1;
      check("t2_enc_unmask", 32'(enc_in), 32'h08);
      wait_empty("t2_grant", 10);
      check("t2_pending_end", 32'(pending_o), 32'h00);

      // stalled grant survives a software clear of its own bit
      gnt_ready_i = 1'b0;
      exp_q.push_back(2);
      req_i = 8'h04;
      tick();
      req_i = 8'h00;
      wait_valid("t3_offer", 10);
      check("t3_idx", 32'(gnt_idx_o), 32'd2);
      clr_i = 8'h04;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_stall_valid", 32'(gnt_valid_o), 32'd1);
         check("t3_stall_idx", 32'(gnt_idx_o), 32'd2);
      end
      clr_i = 8'h00;
      h0 = hs_cnt;
      gnt_ready_i = 1'b1;
      tick(4);
      check("t3_one_hs", 32'(hs_cnt - h0), 32'd1);
      check("t3_pending", 32'(pending_o), 32'h00);
      check("t3_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef IRQ_EDGE_DETECT_EN
      // held level in edge mode yields a single event after 3 cycles
      gnt_ready_i = 1'b0;
      exp_q.push_back(1);
      req_i = 8'h02;
      tick(2);
      check("t4_not_yet", 32'(pending_o[1]), 32'd0);
      tick();
      check("t4_set_lat3", 32'(pending_o[1]), 32'd1);
      tick(7);
      check("t4_single_evt_ovf", 32'(ovf_o), 32'd0);
      req_i = 8'h00;
      tick(2);
      req_i = 8'h02;
      tick(4);
      check("t4_ovf_set", 32'(ovf_o), 32'd1);
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      check("t4_ovf_clr", 32'(ovf_o), 32'd0);
      req_i = 8'h00;
      gnt_ready_i = 1'b1;
      wait_empty("t4_grant", 10);
      tick(3);
      check("t4_pending_end", 32'(pending_o), 32'h00);
`endif

      // event on idx 4 lands on the same edge as its handshake
      gnt_ready_i = 1'b0;
      exp_q.push_back(4); exp_q.push_back(4);
      req_i = 8'h10;
      tick();
      req_i = 8'h00;
      wait_valid("t5_offer", 10);
      tick(2);
      h0 = hs_cnt;
      req_i = 8'h10;
      tick(EVT_LAT - 1);
      gnt_ready_i = 1'b1;
      tick();
      req_i = 8'h00;
      check("t5_hs_done", 32'(hs_cnt - h0), 32'd1);
      check("t5_pending_kept", 32'(pending_o[4]), 32'd1);
      check("t5_no_ovf", 32'(ovf_o), 32'd0);
      wait_empty("t5_second_grant", 10);
      tick();
      check("t5_pending_end", 32'(pending_o), 32'h00);

      // asynchronous reset drops an in-flight grant
      gnt_ready_i = 1'b0;
      exp_q.push_back(6);
      req_i = 8'h40;
      tick();
      req_i = 8'h00;
      wait_valid("t6_offer", 10);
      h0 = hs_cnt;
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", 32'(gnt_valid_o), 32'd0);
      check("t6_async_pending", 32'(pending_o), 32'h00);
      check("t6_async_idx", 32'(gnt_idx_o), 32'd0);
      exp_q.delete();
      tick(2);
      rst_n = 1'b1;
      gnt_ready_i = 1'b1;
      tick(5);
      check("t6_no_regrant", 32'(hs_cnt - h0), 32'd0);
      exp_q.push_back(0);
      req_i = 8'h01;
      tick();
      req_i = 8'h00;
      wait_empty("t6_new_grant", 10);
      tick();
      check("t6_pending_end", 32'(pending_o), 32'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
